// File: rtl/ifetch_buf_pkg.sv
// ifetch_buf_pkg: shared fetch-unit definitions (RV32 opcode constants, word
// size, fetch-entry layout, fetch state encoding, opcode legality helper).
package ifetch_buf_pkg;

    localparam int SIZE_WORD = 4;

    // Fetch-entry layout is {pc, instr, pred}: two XLEN words plus the flag.
    localparam int FE_PRED_W = 1;

    function automatic int fe_width(input int xlen);
        return 2 * xlen + FE_PRED_W;
    endfunction

    typedef enum logic [6:0] {
        R_TYPE  = 7'b0110011,
        I_TYPE  = 7'b0010011,
        I_LOAD  = 7'b0000011,
        S_TYPE  = 7'b0100011,
        B_TYPE  = 7'b1100011,
        I_JALR  = 7'b1100111,
        J_JAL   = 7'b1101111,
        U_AUIPC = 7'b0010111,
        U_LUI   = 7'b0110111
    } opcode_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } fetch_state_e;

    // True for the opcodes the core executes; anything else halts fetch.
    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            R_TYPE, I_TYPE, I_LOAD, S_TYPE, B_TYPE,
            I_JALR, J_JAL, U_AUIPC, U_LUI: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ifetch_buf_predecode.sv
// ifetch_predecode: combinational look at a returning instruction word.
// Produces the next fetch address, the predicted-taken flag and an
// illegal-opcode flag. With IFETCH_BPRED_EN defined, JAL and backward
// branches are predicted taken; otherwise the next address is always pc+4.
module ifetch_predecode
    import ifetch_buf_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] target,
    output logic            pred_taken,
    output logic            illegal
);

    logic [6:0] opc;

    assign opc     = instr[6:0];
    assign illegal = !is_legal_op(opc);

`ifdef IFETCH_BPRED_EN
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_b;

    // Static prediction: JAL always taken, B-type taken only when backward.
    always_comb begin
        imm_j      = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_b      = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        target     = pc + XLEN'(SIZE_WORD);
        pred_taken = 1'b0;
        if (opc == J_JAL) begin
            target     = pc + imm_j;
            pred_taken = 1'b1;
        end else if (opc == B_TYPE && imm_b[XLEN-1]) begin
            target     = pc + imm_b;
            pred_taken = 1'b1;
        end
    end
`else
    logic unused_hi;

    assign unused_hi  = ^instr[XLEN-1:7];
    assign target     = pc + XLEN'(SIZE_WORD);
    assign pred_taken = 1'b0;
`endif

endmodule

// File: rtl/ifetch_buf.sv
// ifetch_buf: fetch address generation, single-outstanding IMEM request
// (1-cycle read latency) and a DEPTH-entry decoupling queue toward decode.
// Build option: IFETCH_BPRED_EN enables static JAL/backward-branch prediction;
// without it fetch is purely sequential and out_pred_taken is tied low.
module ifetch_buf
    import ifetch_buf_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_pred_taken,
    output logic            halt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      instr;
`ifdef IFETCH_BPRED_EN
        logic [FE_PRED_W-1:0] pred;
`endif
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    entry_t          enq_entry;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            halt_q, halt_d;
    fetch_state_e    state_q, state_d;

    logic [XLEN-1:0] pd_target;
    logic            pd_pred;
    logic            pd_illegal;

    logic [XLEN-1:0] next_pc;
    logic            issue;
    logic            credit_ok;
    logic            enq;
    logic            deq;
    logic            halt_now;

    // The returning word is inspected while it is still on imem_rdata so the
    // predicted target can be issued in the same cycle (zero-bubble).
    ifetch_predecode #(.XLEN(XLEN)) u_predecode (
        .instr      (imem_rdata),
        .pc         (inflight_pc_q),
        .target     (pd_target),
        .pred_taken (pd_pred),
        .illegal    (pd_illegal)
    );

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

`ifdef IFETCH_BPRED_EN
    assign out_pred_taken = out_valid & head.pred[0];
`else
    logic unused_pred;

    assign unused_pred    = pd_pred;
    assign out_pred_taken = 1'b0;
`endif

    // Halt shows as soon as the illegal entry reaches the head and then
    // sticks (via halt_q) after that entry has been consumed.
    assign halt_now  = out_valid && !is_legal_op(head.instr[6:0]);
    assign halt      = halt_q | halt_now;

    assign imem_req  = issue;
    assign imem_addr = next_pc;

    // Next fetch address, issue decision and queue pointer/count updates.
    always_comb begin
        // A slot is reserved for the outstanding response; a pop in the same
        // cycle is not credited so the queue can never overflow.
        credit_ok = (int'(count_q) + int'(inflight_q)) < DEPTH;

        next_pc = fetch_pc_q;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (inflight_q) begin
            next_pc = pd_target;
        end

        // An illegal response stops fetch right away, before it is enqueued.
        issue = 1'b0;
        if (rst) begin
            if (redirect_valid) begin
                issue = 1'b1;
            end else if (state_q == ST_RUN && credit_ok && !(inflight_q && pd_illegal)) begin
                issue = 1'b1;
            end
        end

        enq = inflight_q && !redirect_valid;
        deq = out_valid && out_ready && !redirect_valid;

        enq_entry.pc    = inflight_pc_q;
        enq_entry.instr = imem_rdata;
`ifdef IFETCH_BPRED_EN
        enq_entry.pred  = pd_pred;
`endif

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        halt_d   = halt_q;

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = ST_RUN;
            halt_d   = 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CW'(1);
            end
            if (enq && pd_illegal) begin
                state_d = ST_HALTED;
            end
            if (halt_now) begin
                halt_d = 1'b1;
            end
        end

        fetch_pc_d    = next_pc;
        inflight_d    = issue;
        inflight_pc_d = issue ? next_pc : inflight_pc_q;
    end

    // Control state and fetch FSM; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_RUN;
            halt_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            halt_q        <= halt_d;
        end
    end

    // Queue storage; slots outside the valid window are don't-care, no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= enq_entry;
        end
    end

endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: directed scenarios plus randomized redirect/ready/reset
// traffic, checked every cycle against a queue-based behavioural model.
// Build with or without IFETCH_BPRED_EN; expectations follow the macro.
module tb_ifetch_buf;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int K_OTHER = 0;
    localparam int K_JAL   = 1;
    localparam int K_BR    = 2;
    localparam int K_ILL   = 3;

    typedef struct {
        logic [31:0] instr;
        int          kind;
        int          imm;
    } pe_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
        logic        ill;
    } ment_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic        halt;

    ifetch_buf #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    pe_t prog [logic [31:0]];

    // model state
    logic [31:0] m_npc;
    logic        m_busy;
    logic [31:0] m_busy_pc;
    logic        m_halted;
    logic        m_hseen;
    ment_t       m_q [$];

    // memory side
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;

    // last sampled DUT outputs for directed checks
    logic        o_req, o_valid, o_halt, o_pred;
    logic [31:0] o_addr, o_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic pe_t prog_get(input logic [31:0] a);
        pe_t e;
        if (prog.exists(a)) e = prog[a];
        else begin e.instr = NOP; e.kind = K_OTHER; e.imm = 0; end
        return e;
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [31:0] u;
        u = imm;
        return {u[20], u[10:1], u[11], u[19:12], 5'd1, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_b(input int imm);
        logic [31:0] u;
        logic [31:0] r;
        u = imm;
        r = $urandom;
        return {u[12], u[10:5], r[24:20], r[19:15], r[14:12], u[4:1], u[11], 7'h63};
    endfunction

    // Expected next address and prediction for a fetched instruction.
    task automatic predict(input pe_t e, input logic [31:0] pc,
                           output logic [31:0] tgt, output logic tk);
        tgt = pc + 32'd4;
        tk  = 1'b0;
`ifdef IFETCH_BPRED_EN
        if (e.kind == K_JAL || (e.kind == K_BR && e.imm < 0)) begin
            tgt = pc + 32'(e.imm);
            tk  = 1'b1;
        end
`endif
    endtask

    task automatic m_reset();
        m_npc = RST_PC; m_busy = 1'b0; m_busy_pc = RST_PC;
        m_halted = 1'b0; m_hseen = 1'b0; m_q.delete();
    endtask

    task automatic build_prog();
        logic [6:0] ops [7];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100111, 7'b0010111, 7'b0110111};
        prog[32'h108] = '{32'h0200_006F, K_JAL, 32};
        prog[32'h110] = '{32'h0000_0000, K_ILL, 0};
        prog[32'h130] = '{32'hFE00_0CE3, K_BR, -8};
        for (int a = 32'h800; a < 32'h900; a += 4) begin
            int sel;
            int k;
            logic [31:0] w;
            sel = int'($urandom_range(0, 19));
            k = int'($urandom_range(0, 32)) - 16;
            w = $urandom;
            if (sel < 3) prog[a] = '{enc_j(4 * k), K_JAL, 4 * k};
            else if (sel < 6) begin
                if (k == 0) k = -3;
                prog[a] = '{enc_b(4 * k), K_BR, 4 * k};
            end else if (sel == 6) prog[a] = '{{w[31:7], 7'h7F}, K_ILL, 0};
            else prog[a] = '{{w[31:7], ops[$urandom_range(0, 6)]}, K_OTHER, 0};
        end
    endtask

    // One clock: drive inputs, compare DUT against model, advance the model.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        pe_t         rsp, mw;
        logic [31:0] tgt, e_addr;
        logic        tk, e_req, e_halt, hv, rill;
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
        mw = prog_get(mem_addr);
        imem_rdata = mem_pend ? mw.instr : $urandom;
        #1;
        hv = (m_q.size() != 0);
        rsp = prog_get(m_busy_pc);
        predict(rsp, m_busy_pc, tgt, tk);
        rill = m_busy && (rsp.kind == K_ILL);
        e_addr = rv ? rp : (m_busy ? tgt : m_npc);
        e_req = r && (rv || (!m_halted && (m_q.size() + int'(m_busy)) < DEPTH && !rill));
        e_halt = m_hseen || (hv && m_q[0].ill);
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        chk("out_valid", out_valid, hv);
        if (hv) begin
            chk("out_pc", out_pc, m_q[0].pc);
            chk("out_instr", out_instr, m_q[0].instr);
            chk("out_pred", out_pred_taken, m_q[0].pred);
        end else begin
            chk("pred_idle", out_pred_taken, 0);
        end
        chk("halt", halt, e_halt);
        o_req = imem_req; o_addr = imem_addr; o_valid = out_valid;
        o_pc = out_pc; o_pred = out_pred_taken; o_halt = halt;
        mem_pend = imem_req; mem_addr = imem_addr;
        if (!r) begin
            m_reset();
        end else begin
            if (rv) begin
                m_q.delete(); m_halted = 1'b0; m_hseen = 1'b0;
            end else begin
                if (hv && m_q[0].ill) m_hseen = 1'b1;
                if (hv && rdy) void'(m_q.pop_front());
                if (m_busy) begin
                    m_q.push_back('{m_busy_pc, rsp.instr, tk, rill});
                    if (rill) m_halted = 1'b1;
                end
            end
            m_npc = e_addr;
            m_busy = e_req;
            if (e_req) m_busy_pc = e_addr;
        end
    endtask

    task automatic wait_head(input logic [31:0] pc, input string tag);
        int n = 0;
        do begin
            cycle(1, 0, 0, 1);
            n++;
        end while (!(o_valid && o_pc == pc) && n < 20);
        chk(tag, {31'b0, o_valid && o_pc == pc}, 1);
    endtask

    initial begin
        build_prog();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        m_reset();

        // reset state and streaming from RESET_PC
        cycle(0, 0, 0, 1);
        chk("rst_req", o_req, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_halt", o_halt, 0);
        cycle(1, 0, 0, 1);
        chk("c0_req", o_req, 1);
        chk("c0_addr", o_addr, 32'h100);
        chk("c0_valid", o_valid, 0);
        cycle(1, 0, 0, 1);
        chk("c1_valid", o_valid, 0);
        cycle(1, 0, 0, 1);
        chk("c2_pc", o_pc, 32'h100);
        cycle(1, 0, 0, 1);
        chk("c3_pc", o_pc, 32'h104);
        cycle(1, 0, 0, 1);
        chk("c4_pc", o_pc, 32'h108);
`ifdef IFETCH_BPRED_EN
        chk("jal_pred", o_pred, 1);
        cycle(1, 0, 0, 1);
        chk("jal_tgt", o_pc, 32'h128);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        chk("beq_pc", o_pc, 32'h130);
        chk("beq_pred", o_pred, 1);
        cycle(1, 0, 0, 1);
        chk("beq_tgt", o_pc, 32'h128);
`else
        chk("jal_nopred", o_pred, 0);
        cycle(1, 0, 0, 1);
        chk("seq_pc", o_pc, 32'h10C);
        chk("ill_noreq", o_req, 0);
        cycle(1, 0, 0, 1);
        chk("ill_head", o_pc, 32'h110);
        chk("ill_halt", o_halt, 1);
`endif

        // stall with a full queue, then drain without loss
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0);
        chk("full_noreq", o_req, 0);
        chk("full_valid", o_valid, 1);
        chk("full_head", o_pc, 32'h100);
        cycle(1, 0, 0, 1); chk("drain0", o_pc, 32'h100);
        cycle(1, 0, 0, 1); chk("drain1", o_pc, 32'h104);
        cycle(1, 0, 0, 1); chk("drain2", o_pc, 32'h108);
        cycle(1, 0, 0, 1);
`ifdef IFETCH_BPRED_EN
        chk("drain3", o_pc, 32'h128);
`else
        chk("drain3", o_pc, 32'h10C);
`endif

        // redirect with 3 queued entries and a response inflight
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 32'h400, 0);
        chk("rd_req", o_req, 1);
        chk("rd_addr", o_addr, 32'h400);
        cycle(1, 0, 0, 1);
        chk("rd_flushed", o_valid, 0);
        cycle(1, 0, 0, 1);
        chk("rd_head", o_pc, 32'h400);
        cycle(1, 0, 0, 1);
        chk("rd_next", o_pc, 32'h404);

        // illegal opcode halts fetch until a redirect
        cycle(0, 0, 0, 1);
        cycle(1, 1, 32'h110, 1);
        wait_head(32'h110, "halt_head");
        chk("halt_up", o_halt, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 1);
            chk("halt_noreq", o_req, 0);
            chk("halt_sticky", o_halt, 1);
        end
        cycle(1, 1, 32'h200, 1);
        chk("resume_req", o_req, 1);
        chk("resume_addr", o_addr, 32'h200);
        cycle(1, 0, 0, 1);
        chk("halt_clr", o_halt, 0);
        wait_head(32'h200, "resume_head");

        // redirect + full queue + dequeue in one cycle
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);
        chk("full2_noreq", o_req, 0);
        cycle(1, 1, 32'h200, 1);
        chk("rfd_req", o_req, 1);
        chk("rfd_addr", o_addr, 32'h200);
        cycle(1, 0, 0, 1);
        chk("rfd_empty", o_valid, 0);
        cycle(1, 0, 0, 1);
        chk("rfd_head", o_pc, 32'h200);

        // address wrap
        cycle(1, 1, 32'hFFFF_FFF8, 1);
        wait_head(32'hFFFF_FFF8, "wrap_head");
        cycle(1, 0, 0, 1);
        chk("wrap_ffc", o_pc, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 1);
        chk("wrap_zero", o_pc, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, rv, rdy;
            logic [31:0] rp;
            r   = ($urandom_range(0, 199) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 6))
                0:       rp = 32'h100;
                1:       rp = 32'h110;
                2:       rp = 32'h130;
                3:       rp = 32'h200;
                4:       rp = 32'h400;
                5:       rp = 32'hFFFF_FFF8;
                default: rp = 32'h800 + 32'(4 * $urandom_range(0, 63));
            endcase
            cycle(r, rv, rp, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_buf.md
# ifetch_buf

Parametrised instruction-fetch unit with a decoupling fetch queue. It generates fetch addresses, drives a synchronous instruction memory (1-cycle read latency), optionally applies static prediction (JAL, backward branches), and buffers fetched {pc, instr, pred} entries for decode behind a valid/ready handshake. It sits between the PC/IMEM front end and the decode stage, and accepts redirects from execute.

## Interface
- XLEN, 32: address/instruction width
- DEPTH, 4: fetch-queue entries (power of two, ≥2)
- RESET_PC, 32'h0: first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- imem_req  out  1  fetch request this cycle
- imem_addr  out  XLEN  fetch address (word aligned)
- imem_rdata  in  XLEN  instruction word, valid the cycle after imem_req
- redirect_valid  in  1  execute-stage mispredict/jump redirect
- redirect_pc  in  XLEN  redirect target
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  XLEN  head instruction
- out_pc  out  XLEN  head PC
- out_pred_taken  out  1  head was predicted taken
- halt  out  1  illegal opcode reached head; sticky

## Operation
- Registers: fetch_pc, inflight (1 bit), inflight_pc, queue (DEPTH entries, rd/wr pointers, count 0..DEPTH), state {RUN, HALTED}.
- Issue: in RUN, imem_req=1 when count + inflight + 1 ≤ DEPTH (same-cycle pop is not credited). Exactly one outstanding request at a time.
- Next address (combinational): redirect_valid → redirect_pc; else a response this cycle → predicted target, or inflight_pc+4; else fetch_pc. imem_addr = this value; fetch_pc loads it.
- Response: when inflight, imem_rdata is enqueued with inflight_pc and the pred flag. Enqueue and dequeue in the same cycle leave count unchanged. Dequeue on out_valid && out_ready.
- Halt: a response whose opcode is not one of R, I, I_LOAD, S, B, JALR, JAL, AUIPC, LUI is still enqueued, and state → HALTED (no further issue). halt rises when that entry is at the head (out_valid=1). It stays high until redirect or reset.
- Redirect (highest priority): flush the queue (count=0, pointers=0), discard the inflight response, state → RUN, and issue at redirect_pc in the same cycle. It overrides a simultaneous enqueue, dequeue, or halt.
- PC arithmetic is modulo 2^XLEN; address wrap at 0xFFFF_FFFC → 0 is legal.

## Timing
- Reset (rst=0 at a clk edge): fetch_pc=RESET_PC, count=0, inflight=0, state=RUN, out_valid=0, out_pred_taken=0, halt=0, imem_req=0. First request is issued in the cycle after rst deasserts.
- Latency: request at cycle t, enqueued at edge t+1, out_valid in cycle t+2 when the queue was empty.
- Steady state: one instruction per cycle, including through predicted-taken JAL/branches (zero-bubble).
- Full queue: issue stalls; out_instr/out_pc stay stable while out_valid && !out_ready.
- Reset asserted mid-operation drops the inflight response and all queue entries.

## Configuration
- IFETCH_BPRED_EN defined: JAL → pc+immJ, pred=1. B-type with imm<0 → pc+immB, pred=1. Everything else → pc+4, pred=0.
- Not defined: always pc+4, out_pred_taken tied to 0, and the immediate decode logic is absent.

## Structure
- Shared package (existing defines file): opcode constants (R_TYPE … U_LUI), SIZE_WORD, and a fetch-entry struct/macro widths {pc, instr, pred}.
- One sub-module: ifetch_predecode. It is combinational; input is instr and pc, outputs are target, pred_taken, and illegal.

## Test plan
- Reset with RESET_PC=0x100 and NOPs, out_ready=1 → out_pc 0x100, 0x104, 0x108 on consecutive cycles; first valid arrives 2 cycles after reset release.
- out_ready=0 for 10 cycles, DEPTH=4 → count saturates at 4, imem_req=0, head remains 0x100; release → no entry lost or duplicated.
- Redirect to 0x400 while the queue holds 3 entries and a request is inflight → next out_pc=0x400; flushed PCs never appear.
- BPRED_EN, JAL +0x20 at 0x108 → next out_pc 0x128, pred=1. Backward BEQ −8 at 0x130 → 0x128. Macro off → 0x10C, pred=0.
- Word 0x00000000 at 0x110 → halt=1 when 0x110 heads, no request issued after it; redirect to 0x200 → halt=0, fetch resumes.
- Redirect and queue full and dequeue in the same cycle → count=0, issue at redirect_pc.
